// File: rtl/tb_addr_map_pkg.sv
// Address map, response codes and FSM state types for the AXI4-Lite router.
package tb_addr_map_pkg;

    import tb_pkg::*;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] mask;
    } addr_win_t;

    localparam int NUM_WIN = 5;
    localparam int SEL_W   = 3;

    localparam logic [63:0] RAM_MASK = 64'hFFFF_FFFF_FFE0_0000;
    localparam logic [63:0] PER_MASK = 64'hFFFF_FFFF_FFFF_0000;

    // Index order is the priority order: lower index wins on overlap.
    localparam addr_win_t TB_ADDR_MAP [NUM_WIN] = '{
        '{base: BRAM_BASE,      mask: RAM_MASK},
        '{base: APB_M_DCM_BASE, mask: PER_MASK},
        '{base: APB_M_PNS_BASE, mask: PER_MASK},
        '{base: M_AXI_HSM_BASE, mask: PER_MASK},
        '{base: M_AXI_REG_BASE, mask: PER_MASK}
    };

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_ERR
    } wr_st_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_RESP,
        R_ERR
    } rd_st_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tb_pkg.sv
// Shared testbench address constants: base address of every slave window.
package tb_pkg;

    localparam logic [63:0] BRAM_BASE      = 64'h0000_0202_0000_0000;
    localparam logic [63:0] APB_M_DCM_BASE = 64'h0000_0202_0100_0000;
    localparam logic [63:0] APB_M_PNS_BASE = 64'h0000_0202_0101_0000;
    localparam logic [63:0] M_AXI_HSM_BASE = 64'h0000_0202_0102_0000;
    localparam logic [63:0] M_AXI_REG_BASE = 64'h0000_0202_0103_0000;

endpackage

// File: rtl/tb_axil_addr_router_decode.sv
// Combinational window decoder: address in, hit flag and slave index out.
module tb_addr_decode
    import tb_addr_map_pkg::*;
(
    input  logic [63:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((addr & TB_ADDR_MAP[i].mask) == TB_ADDR_MAP[i].base) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/tb_axil_addr_router.sv
// AXI4-Lite 1-to-NUM_SLV router with local DECERR for unmapped addresses.
// Optional DECERR counters: define TB_ROUTER_DECERR_CNT_EN.
module tb_axil_addr_router
    import tb_addr_map_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = NUM_WIN,
    parameter int STRB_W  = DATA_W / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDR_W-1:0]         s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_W-1:0]         s_wdata,
    input  logic [STRB_W-1:0]         s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_W-1:0]         s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [NUM_SLV-1:0]        m_awvalid,
    input  logic [NUM_SLV-1:0]        m_awready,
    output logic [NUM_SLV*ADDR_W-1:0] m_awaddr,
    output logic [NUM_SLV*DATA_W-1:0] m_wdata,
    output logic [NUM_SLV*STRB_W-1:0] m_wstrb,
    output logic [NUM_SLV-1:0]        m_wvalid,
    input  logic [NUM_SLV-1:0]        m_wready,
    input  logic [NUM_SLV-1:0]        m_bvalid,
    input  logic [NUM_SLV*2-1:0]      m_bresp,
    output logic [NUM_SLV-1:0]        m_bready,
    output logic [NUM_SLV-1:0]        m_arvalid,
    input  logic [NUM_SLV-1:0]        m_arready,
    output logic [NUM_SLV*ADDR_W-1:0] m_araddr,
    input  logic [NUM_SLV-1:0]        m_rvalid,
    input  logic [NUM_SLV*DATA_W-1:0] m_rdata,
    input  logic [NUM_SLV*2-1:0]      m_rresp,
    output logic [NUM_SLV-1:0]        m_rready
`ifdef TB_ROUTER_DECERR_CNT_EN
    ,
    output logic [15:0]               wr_decerr_cnt,
    output logic [15:0]               rd_decerr_cnt
`endif
);

    wr_st_e             wr_st, wr_st_n;
    rd_st_e             rd_st, rd_st_n;
    logic               aw_held, aw_held_n;
    logic               w_held, w_held_n;
    logic               ar_held, ar_held_n;
    logic [SEL_W-1:0]   wsel, wsel_n;
    logic [SEL_W-1:0]   rsel, rsel_n;
    logic [ADDR_W-1:0]  aw_addr;
    logic [ADDR_W-1:0]  ar_addr;
    logic [DATA_W-1:0]  w_data;
    logic [STRB_W-1:0]  w_strb;
    logic               w_hit, r_hit;
    logic [SEL_W-1:0]   w_idx, r_idx;
    logic [NUM_SLV-1:0] wsel_oh, rsel_oh;

    tb_addr_decode u_wr_dec (
        .addr (aw_addr),
        .hit  (w_hit),
        .sel  (w_idx)
    );

    tb_addr_decode u_rd_dec (
        .addr (ar_addr),
        .hit  (r_hit),
        .sel  (r_idx)
    );

    assign wsel_oh = NUM_SLV'(1) << wsel;
    assign rsel_oh = NUM_SLV'(1) << rsel;

    // Readies are gated by aresetn so the master sees 0 during reset.
    assign s_awready = aresetn && (wr_st == W_IDLE) && !aw_held;
    assign s_wready  = aresetn && (wr_st == W_IDLE) && !w_held;
    assign s_arready = aresetn && (rd_st == R_IDLE) && !ar_held;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_st   <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wsel    <= '0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            wr_st   <= wr_st_n;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            wsel    <= wsel_n;
            if (s_awvalid && s_awready) begin
                aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
        end
    end

    // The held flags double as "still to be accepted" while forwarding.
    always_comb begin
        wr_st_n   = wr_st;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        wsel_n    = wsel;
        unique case (wr_st)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    if (w_hit) begin
                        wr_st_n = W_FWD;
                        wsel_n  = w_idx;
                    end else begin
                        wr_st_n   = W_ERR;
                        aw_held_n = 1'b0;
                        w_held_n  = 1'b0;
                    end
                end else begin
                    if (s_awvalid && s_awready) aw_held_n = 1'b1;
                    if (s_wvalid && s_wready)   w_held_n  = 1'b1;
                end
            end
            W_FWD: begin
                if (aw_held && m_awready[wsel]) aw_held_n = 1'b0;
                if (w_held && m_wready[wsel])   w_held_n  = 1'b0;
                if (!aw_held_n && !w_held_n)    wr_st_n   = W_RESP;
            end
            W_RESP: begin
                if (m_bvalid[wsel] && s_bready) wr_st_n = W_IDLE;
            end
            W_ERR: begin
                if (s_bready) wr_st_n = W_IDLE;
            end
        endcase
    end

    assign m_awvalid = (wr_st == W_FWD && aw_held) ? wsel_oh : '0;
    assign m_wvalid  = (wr_st == W_FWD && w_held) ? wsel_oh : '0;
    assign m_bready  = (wr_st == W_RESP) ? (wsel_oh & {NUM_SLV{s_bready}}) : '0;
    assign m_awaddr  = {NUM_SLV{aw_addr}};
    assign m_wdata   = {NUM_SLV{w_data}};
    assign m_wstrb   = {NUM_SLV{w_strb}};

    always_comb begin
        s_bvalid = 1'b0;
        s_bresp  = RESP_OKAY;
        unique case (wr_st)
            W_RESP: begin
                s_bvalid = m_bvalid[wsel];
                s_bresp  = m_bresp[wsel*2 +: 2];
            end
            W_ERR: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_DECERR;
            end
            W_IDLE, W_FWD: begin
                s_bvalid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_st   <= R_IDLE;
            ar_held <= 1'b0;
            rsel    <= '0;
            ar_addr <= '0;
        end else begin
            rd_st   <= rd_st_n;
            ar_held <= ar_held_n;
            rsel    <= rsel_n;
            if (s_arvalid && s_arready) begin
                ar_addr <= s_araddr;
            end
        end
    end

    always_comb begin
        rd_st_n   = rd_st;
        ar_held_n = ar_held;
        rsel_n    = rsel;
        unique case (rd_st)
            R_IDLE: begin
                if (ar_held) begin
                    ar_held_n = 1'b0;
                    if (r_hit) begin
                        rd_st_n = R_FWD;
                        rsel_n  = r_idx;
                    end else begin
                        rd_st_n = R_ERR;
                    end
                end else if (s_arvalid && s_arready) begin
                    ar_held_n = 1'b1;
                end
            end
            R_FWD: begin
                if (m_arready[rsel]) rd_st_n = R_RESP;
            end
            R_RESP: begin
                if (m_rvalid[rsel] && s_rready) rd_st_n = R_IDLE;
            end
            R_ERR: begin
                if (s_rready) rd_st_n = R_IDLE;
            end
        endcase
    end

    assign m_arvalid = (rd_st == R_FWD) ? rsel_oh : '0;
    assign m_rready  = (rd_st == R_RESP) ? (rsel_oh & {NUM_SLV{s_rready}}) : '0;
    assign m_araddr  = {NUM_SLV{ar_addr}};

    always_comb begin
        s_rvalid = 1'b0;
        s_rresp  = RESP_OKAY;
        s_rdata  = '0;
        unique case (rd_st)
            R_RESP: begin
                s_rvalid = m_rvalid[rsel];
                s_rresp  = m_rresp[rsel*2 +: 2];
                s_rdata  = m_rdata[rsel*DATA_W +: DATA_W];
            end
            R_ERR: begin
                s_rvalid = 1'b1;
                s_rresp  = RESP_DECERR;
            end
            R_IDLE, R_FWD: begin
                s_rvalid = 1'b0;
            end
        endcase
    end

`ifdef TB_ROUTER_DECERR_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_decerr_cnt <= '0;
            rd_decerr_cnt <= '0;
        end else begin
            if (wr_st == W_ERR && s_bready) begin
                wr_decerr_cnt <= sat_inc(wr_decerr_cnt);
            end
            if (rd_st == R_ERR && s_rready) begin
                rd_decerr_cnt <= sat_inc(rd_decerr_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tb_axil_addr_router.sv
// Self-checking bench for tb_axil_addr_router: vector table plus corner sequences.
module tb_tb_axil_addr_router;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int NS = 5;
    localparam int SW = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid, s_awready;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_wvalid, s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid, s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid, s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid, s_rready;
    logic [NS-1:0]   m_awvalid, m_awready;
    logic [NS*AW-1:0] m_awaddr;
    logic [NS*DW-1:0] m_wdata;
    logic [NS*SW-1:0] m_wstrb;
    logic [NS-1:0]   m_wvalid, m_wready;
    logic [NS-1:0]   m_bvalid, m_bready;
    logic [NS*2-1:0] m_bresp;
    logic [NS-1:0]   m_arvalid, m_arready;
    logic [NS*AW-1:0] m_araddr;
    logic [NS-1:0]   m_rvalid, m_rready;
    logic [NS*DW-1:0] m_rdata;
    logic [NS*2-1:0] m_rresp;
`ifdef TB_ROUTER_DECERR_CNT_EN
    logic [15:0]     wr_decerr_cnt, rd_decerr_cnt;
`endif

    always #5 aclk = ~aclk;

    tb_axil_addr_router dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
`ifdef TB_ROUTER_DECERR_CNT_EN
        ,
        .wr_decerr_cnt(wr_decerr_cnt), .rd_decerr_cnt(rd_decerr_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          rd;
        logic [63:0] addr;
        logic [31:0] data;
        int          sel;
        logic [1:0]  resp;
        int          dly;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[12];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            e.resp  = 2'bxx;
            e.rdata = 'x;
        end else begin
            e = sbq.pop_front();
        end
    endtask

    task automatic wr(input logic [63:0] a, input logic [31:0] d, input int sel,
                      input logic [1:0] br, input int w_lead);
        exp_t        e;
        int          n;
        logic [NS-1:0] oh;
        e.resp  = (sel < 0) ? 2'b11 : br;
        e.rdata = '0;
        sbq.push_back(e);
        oh = (sel < 0) ? '0 : NS'(1) << sel;
        if (w_lead > 0) begin
            s_wdata = d; s_wstrb = '1; s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 20) begin tick(); n++; end
            chk("w_accept_to", 64'(n < 20), 64'd1);
            tick();
            s_wvalid = 1'b0;
            repeat (w_lead - 1) tick();
            chk("w_early_fwd", 64'(m_wvalid), 64'd0);
        end
        s_awaddr = a; s_awvalid = 1'b1;
        if (w_lead == 0) begin
            s_wdata = d; s_wstrb = '1; s_wvalid = 1'b1;
        end
        n = 0;
        while (!(s_awready && (w_lead > 0 || s_wready)) && n < 20) begin tick(); n++; end
        chk("aw_accept_to", 64'(n < 20), 64'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        chk("m_awvalid", 64'(m_awvalid), 64'(oh));
        chk("m_wvalid", 64'(m_wvalid), 64'(oh));
        if (sel >= 0) begin
            chk("m_awaddr", m_awaddr[sel*AW +: AW], a);
            chk("m_wdata", 64'(m_wdata[sel*DW +: DW]), 64'(d));
            m_awready = '1; m_wready = '1;
            tick();
            m_awready = '0; m_wready = '0;
            chk("b_early", 64'(s_bvalid), 64'd0);
            m_bresp = '1;
            m_bresp[sel*2 +: 2] = br;
            m_bvalid = oh;
        end
        s_bready = 1'b1;
        #1;
        n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        chk("b_wait_to", 64'(n < 20), 64'd1);
        pop_exp(e);
        chk("s_bresp", 64'(s_bresp), 64'(e.resp));
        tick();
        s_bready = 1'b0; m_bvalid = '0;
    endtask

    task automatic rd(input logic [63:0] a, input int sel, input logic [31:0] d, input int dly);
        exp_t        e;
        int          n;
        logic [NS-1:0] oh;
        e.resp  = (sel < 0) ? 2'b11 : 2'b00;
        e.rdata = (sel < 0) ? '0 : d;
        sbq.push_back(e);
        oh = (sel < 0) ? '0 : NS'(1) << sel;
        s_araddr = a; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin tick(); n++; end
        chk("ar_accept_to", 64'(n < 20), 64'd1);
        tick();
        s_arvalid = 1'b0;
        tick();
        chk("m_arvalid", 64'(m_arvalid), 64'(oh));
        s_rready = 1'b1;
        if (sel >= 0) begin
            chk("m_araddr", m_araddr[sel*AW +: AW], a);
            m_arready = '1;
            tick();
            m_arready = '0;
            for (int k = 0; k < dly; k++) begin
                chk("r_early", 64'(s_rvalid), 64'd0);
                tick();
            end
            for (int k = 0; k < NS; k++) m_rdata[k*DW +: DW] = $urandom;
            m_rdata[sel*DW +: DW] = d;
            m_rresp = '1;
            m_rresp[sel*2 +: 2] = 2'b00;
            m_rvalid = oh;
        end
        #1;
        n = 0;
        while (!s_rvalid && n < 20) begin tick(); n++; end
        chk("r_wait_to", 64'(n < 20), 64'd1);
        pop_exp(e);
        chk("s_rresp", 64'(s_rresp), 64'(e.resp));
        chk("s_rdata", 64'(s_rdata), 64'(e.rdata));
        tick();
        s_rready = 1'b0; m_rvalid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0]  = '{0, 64'h0000_0202_0103_0010, 32'hCAFE_F00D,  4, 2'b00, 0};
        vt[1]  = '{1, 64'h0000_0202_0101_0004, 32'h1234_5678,  2, 2'b00, 5};
        vt[2]  = '{1, 64'h0000_0300_DEAD_0000, 32'h0,         -1, 2'b11, 0};
        vt[3]  = '{0, 64'h0000_0202_001F_FFFC, 32'h1111_2222,  0, 2'b10, 0};
        vt[4]  = '{0, 64'h0000_0202_0020_0000, 32'h3333_4444, -1, 2'b11, 0};
        vt[5]  = '{1, 64'h0000_0202_0100_FFFC, 32'hA5A5_5A5A,  1, 2'b00, 0};
        vt[6]  = '{0, 64'h0000_0202_0102_0000, 32'h0BAD_BEEF,  3, 2'b01, 0};
        vt[7]  = '{1, 64'h0000_0202_0103_0008, 32'hFEED_FACE,  4, 2'b00, 2};
        vt[8]  = '{1, 64'h0000_0202_0000_0000, 32'h0000_0001,  0, 2'b00, 1};
        vt[9]  = '{0, 64'h0000_0202_0104_0000, 32'h5555_AAAA, -1, 2'b11, 0};
        vt[10] = '{0, 64'h0000_0202_0101_0040, 32'h7777_8888,  2, 2'b10, 0};
        vt[11] = '{1, 64'h0000_0202_0102_FFFC, 32'h9999_0000,  3, 2'b00, 3};

        aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
        m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
        repeat (3) tick();
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'd0);
        chk("rst_rdata", 64'(s_rdata), 64'd0);
        chk("rst_awaddr", m_awaddr[0 +: AW], 64'd0);
        aresetn = 1'b1;
        #1;
        chk("rel_awready", 64'(s_awready), 64'd1);
        chk("rel_arready", 64'(s_arready), 64'd1);
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vt[i].rd) rd(vt[i].addr, vt[i].sel, vt[i].data, vt[i].dly);
            else          wr(vt[i].addr, vt[i].data, vt[i].sel, vt[i].resp, 0);
        end
`ifdef TB_ROUTER_DECERR_CNT_EN
        chk("wr_cnt", 64'(wr_decerr_cnt), 64'd2);
        chk("rd_cnt", 64'(rd_decerr_cnt), 64'd1);
`endif

        // W leads AW by three cycles.
        wr(64'h0000_0202_0000_0100, 32'hDEAD_C0DE, 0, 2'b00, 3);

        // DECERR write with s_bready stalled.
        s_awaddr = 64'h0000_0400_0000_0000; s_awvalid = 1;
        s_wdata = 32'h1; s_wstrb = '1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_bvalid", 64'(s_bvalid), 64'd1);
            chk("stall_bresp", 64'(s_bresp), 64'd3);
            chk("stall_awready", 64'(s_awready), 64'd0);
            tick();
        end
        s_bready = 1;
        #1;
        chk("stall_bvalid_hs", 64'(s_bvalid), 64'd1);
        tick();
        s_bready = 0;
        chk("stall_done_awready", 64'(s_awready), 64'd1);
        chk("stall_done_bvalid", 64'(s_bvalid), 64'd0);
`ifdef TB_ROUTER_DECERR_CNT_EN
        chk("wr_cnt_stall", 64'(wr_decerr_cnt), 64'd3);
`endif

        // Reset while forwarding to slave 1.
        s_awaddr = 64'h0000_0202_0100_0020; s_awvalid = 1;
        s_wdata = 32'h4242_4242; s_wstrb = '1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        tick();
        chk("pre_rst_awvalid", 64'(m_awvalid), 64'h2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_awvalid", 64'(m_awvalid), 64'd0);
        chk("async_wvalid", 64'(m_wvalid), 64'd0);
        chk("async_awready", 64'(s_awready), 64'd0);
        chk("async_wready", 64'(s_wready), 64'd0);
        chk("async_awaddr", m_awaddr[AW +: AW], 64'd0);
`ifdef TB_ROUTER_DECERR_CNT_EN
        chk("rst_cnt", 64'({wr_decerr_cnt, rd_decerr_cnt}), 64'd0);
`endif
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        n = 0;
        chk("post_rst_bvalid", 64'(s_bvalid), 64'(n));
        wr(64'h0000_0202_0100_0020, 32'h0F0F_1234, 1, 2'b00, 0);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
